// File: rtl/clk_div_pkg.sv
// Shared constants and mode encoding for the clk_125 divider bank.
package clk_div_pkg;

  localparam int          CW_DEFAULT      = 24;
  localparam int unsigned DEF_DIV_DEFAULT = 8333333;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active terminal count/mode, one-deep shadow
// register that is applied at the next wrap, disable, or sync.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int             CW       = CW_DEFAULT,
  parameter logic [CW-1:0]  DEF_DIV  = CW'(DEF_DIV_DEFAULT),
  parameter mode_e          DEF_MODE = MODE_TOGGLE
) (
  input  logic          clk_125,
  input  logic          rst,
  input  logic          en,
  input  logic          sync,
  input  logic          wr,
  input  logic [CW-1:0] wr_div,
  input  mode_e         wr_mode,
  output logic          pending,
  output logic          clk_out,
  output logic          tick
);

  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] tc, tc_nxt;
  logic [CW-1:0] shd_div, shd_div_nxt;
  mode_e         mode, mode_nxt;
  mode_e         shd_mode, shd_mode_nxt;
  logic          pend_nxt;
  logic          clk_nxt;
  logic          tick_nxt;
  logic          wrap;

  // NOTE: every variable gets its default before any branch, so no path
  // through this block can leave one unassigned and infer a latch.
  always_comb begin
    cnt_nxt      = cnt;
    tc_nxt       = tc;
    mode_nxt     = mode;
    shd_div_nxt  = shd_div;
    shd_mode_nxt = shd_mode;
    pend_nxt     = pending;
    clk_nxt      = clk_out;
    tick_nxt     = 1'b0;
    wrap         = (cnt == tc);

    if (wr) begin
      shd_div_nxt  = wr_div;
      shd_mode_nxt = wr_mode;
    end

    if (sync || !en) begin
      // Stopped or restarting: a write on this edge goes straight to the
      // active registers, otherwise any waiting shadow is taken.
      cnt_nxt  = '0;
      clk_nxt  = 1'b0;
      pend_nxt = 1'b0;
      if (wr) begin
        tc_nxt   = wr_div;
        mode_nxt = wr_mode;
      end else if (pending) begin
        tc_nxt   = shd_div;
        mode_nxt = shd_mode;
      end
    end else if (wrap) begin
      cnt_nxt  = '0;
      tick_nxt = 1'b1;
      pend_nxt = wr;
      if (pending) begin
        tc_nxt   = shd_div;
        mode_nxt = shd_mode;
      end
      // Output follows the mode in force from this edge on; a channel
      // leaving pulse mode restarts its toggle level from 0.
      if (mode_nxt == MODE_PULSE)  clk_nxt = 1'b1;
      else if (mode == MODE_PULSE) clk_nxt = 1'b0;
      else                         clk_nxt = !clk_out;
    end else begin
      cnt_nxt = cnt + CW'(1);
      if (mode == MODE_PULSE) clk_nxt = 1'b0;
      if (wr) pend_nxt = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments only; the async
  // reset clears the outputs immediately, without waiting for an edge.
  always_ff @(posedge clk_125 or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      tc       <= DEF_DIV;
      mode     <= DEF_MODE;
      shd_div  <= DEF_DIV;
      shd_mode <= DEF_MODE;
      pending  <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      tc       <= tc_nxt;
      mode     <= mode_nxt;
      shd_div  <= shd_div_nxt;
      shd_mode <= shd_mode_nxt;
      pending  <= pend_nxt;
      clk_out  <= clk_nxt;
      tick     <= tick_nxt;
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// NCH-channel programmable clock/tick generator in the clk_125 domain;
// holds config decode and the per-channel ready mux.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int          NCH      = 4,
  parameter int          CW       = CW_DEFAULT,
  parameter int unsigned DEF_DIV  = DEF_DIV_DEFAULT,
  parameter bit          DEF_MODE = 1'b0,
  // Derived; not meant to be overridden.
  parameter int          CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk_125,
  input  logic           rst,
  input  logic [NCH-1:0] en,
  input  logic           sync,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_div,
  input  logic           cfg_mode,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick
);

  logic [NCH-1:0]      pending;
  logic [2**CHW-1:0]   pend_ext;
  logic [NCH-1:0]      wr;

  // Unused select codes read as not pending, so writes to them are
  // accepted and dropped.
  always_comb begin
    pend_ext            = '0;
    pend_ext[NCH-1:0]   = pending;
  end

  assign cfg_ready = !pend_ext[cfg_ch];

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign wr[i] = cfg_valid && cfg_ready && (cfg_ch == CHW'(i));

    clk_div_chan #(
      .CW       (CW),
      .DEF_DIV  (CW'(DEF_DIV)),
      .DEF_MODE (mode_e'(DEF_MODE))
    ) u_chan (
      .clk_125 (clk_125),
      .rst     (rst),
      .en      (en[i]),
      .sync    (sync),
      .wr      (wr[i]),
      .wr_div  (cfg_div),
      .wr_mode (mode_e'(cfg_mode)),
      .pending (pending[i]),
      .clk_out (clk_out[i]),
      .tick    (tick[i])
    );
  end

endmodule
